// File: rtl/kof_pkg.sv
// Shared types and default animation frame counts for the KOF character blocks.
package kof_pkg;

    typedef enum logic [7:0] {
        ST_STAND   = 8'd0,
        ST_ATTACK  = 8'd1,
        ST_MOVEL   = 8'd2,
        ST_MOVER   = 8'd3,
        ST_DEFENSE = 8'd4,
        ST_HURT    = 8'd5,
        ST_DIE     = 8'd6
    } char_state_t;

    typedef enum logic [7:0] {
        GS_START    = 8'd0,
        GS_GAME     = 8'd1,
        GS_GAMEOVER = 8'd2
    } game_state_t;

    localparam int DEF_TICKS_PER_FRAME = 4;
    localparam int DEF_STAND_FRAMES    = 9;
    localparam int DEF_ATTACK_FRAMES   = 6;
    localparam int DEF_FORWARD_FRAMES  = 10;
    localparam int DEF_BACKWARD_FRAMES = 9;
    localparam int DEF_DEFENSE_FRAMES  = 1;
    localparam int DEF_HURT_FRAMES     = 5;
    localparam int DEF_DIE_FRAMES      = 5;

endpackage

// File: rtl/anim_tick_gen.sv
// Brings the slow frame_clk into the Clk domain and divides its rising edges
// down to one anim_tick pulse per animation frame.
module anim_tick_gen #(
    parameter int TICKS_PER_FRAME = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    input  logic clear,
    output logic anim_tick
);

    localparam int DW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [DW-1:0] LAST = DW'(TICKS_PER_FRAME - 1);

    // bits [1:0] are the synchronizer, bit [2] is the previous value for edge detect
    logic [2:0]    sync;
    logic [DW-1:0] divider;
    logic          edge_det;

    assign edge_det = sync[1] & ~sync[2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1], sync[0], frame_clk};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            divider   <= '0;
            anim_tick <= 1'b0;
        end else if (clear) begin
            divider   <= '0;
            anim_tick <= 1'b0;
        end else begin
            anim_tick <= 1'b0;
            if (edge_det) begin
                if (divider == LAST) begin
                    divider   <= '0;
                    anim_tick <= 1'b1;
                end else begin
                    divider <= divider + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/iori_anim_ctrl.sv
// Player-2 (Iori) animation sequencer: arbitrates requests and combat events
// into a character state and frame index, advancing once per anim_tick.
module iori_anim_ctrl
    import kof_pkg::*;
#(
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int STAND_FRAMES    = DEF_STAND_FRAMES,
    parameter int ATTACK_FRAMES   = DEF_ATTACK_FRAMES,
    parameter int FORWARD_FRAMES  = DEF_FORWARD_FRAMES,
    parameter int BACKWARD_FRAMES = DEF_BACKWARD_FRAMES,
    parameter int DEFENSE_FRAMES  = DEF_DEFENSE_FRAMES,
    parameter int HURT_FRAMES     = DEF_HURT_FRAMES,
    parameter int DIE_FRAMES      = DEF_DIE_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] game_state,
    input  logic       move_l_req,
    input  logic       move_r_req,
    input  logic       attack_req,
    input  logic       defense_req,
    input  logic       hit_in,
    input  logic       die_in,
    output logic [7:0] character2_state,
    output logic [7:0] frame_num,
    output logic       move_l2,
    output logic       move_r2,
    output logic       attack,
    output logic       hurt,
    output logic       die2,
    output logic       stand2,
    output logic       anim_tick
);

    char_state_t state, state_nxt, arb_state;
    logic [7:0]  frame_nxt;
    logic        attack_pend, hurt_pend, hit_prev;
    logic        game_on, rearb, attack_enter, hurt_enter;

    function automatic logic [7:0] last_frame(input char_state_t s);
        case (s)
            ST_STAND:   return 8'(STAND_FRAMES - 1);
            ST_ATTACK:  return 8'(ATTACK_FRAMES - 1);
            ST_MOVEL:   return 8'(FORWARD_FRAMES - 1);
            ST_MOVER:   return 8'(BACKWARD_FRAMES - 1);
            ST_DEFENSE: return 8'(DEFENSE_FRAMES - 1);
            ST_HURT:    return 8'(HURT_FRAMES - 1);
            ST_DIE:     return 8'(DIE_FRAMES - 1);
            default:    return 8'd0;
        endcase
    endfunction

    assign game_on = (game_state == GS_GAME);

    anim_tick_gen #(
        .TICKS_PER_FRAME(TICKS_PER_FRAME)
    ) u_tick_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .clear    (~game_on),
        .anim_tick(anim_tick)
    );

    always_comb begin
        arb_state = ST_STAND;
        if (die_in)                        arb_state = ST_DIE;
        else if (hurt_pend)                arb_state = ST_HURT;
        else if (attack_pend)              arb_state = ST_ATTACK;
        else if (defense_req)              arb_state = ST_DEFENSE;
        else if (move_l_req && !move_r_req) arb_state = ST_MOVEL;
        else if (move_r_req && !move_l_req) arb_state = ST_MOVER;
    end

    // One-shots only yield to higher-priority events or at their last frame;
    // looping states re-arbitrate every tick and keep counting if reselected.
    always_comb begin
        state_nxt = state;
        frame_nxt = frame_num;
        rearb     = 1'b0;
        if (anim_tick) begin
            case (state)
                ST_DIE: begin
                    if (frame_num < last_frame(ST_DIE)) frame_nxt = frame_num + 8'd1;
                end
                ST_ATTACK: begin
                    if (die_in || hurt_pend || frame_num >= last_frame(ST_ATTACK)) rearb = 1'b1;
                    else frame_nxt = frame_num + 8'd1;
                end
                ST_HURT: begin
                    if (die_in || frame_num >= last_frame(ST_HURT)) rearb = 1'b1;
                    else frame_nxt = frame_num + 8'd1;
                end
                default: rearb = 1'b1;
            endcase
            if (rearb) begin
                state_nxt = arb_state;
                frame_nxt = 8'd0;
                if (arb_state == state && state != ST_ATTACK && state != ST_HURT
                    && state != ST_DEFENSE && frame_num < last_frame(state)) begin
                    frame_nxt = frame_num + 8'd1;
                end
            end
        end
    end

    assign attack_enter = anim_tick && state_nxt == ST_ATTACK && frame_nxt == 8'd0;
    assign hurt_enter   = anim_tick && state_nxt == ST_HURT && frame_nxt == 8'd0;

    // Outside active play everything is held at stand, frame 0, nothing pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_STAND;
            frame_num   <= 8'd0;
            attack_pend <= 1'b0;
            hurt_pend   <= 1'b0;
            hit_prev    <= 1'b0;
        end else begin
            hit_prev <= hit_in;
            if (!game_on) begin
                state       <= ST_STAND;
                frame_num   <= 8'd0;
                attack_pend <= 1'b0;
                hurt_pend   <= 1'b0;
            end else begin
                state     <= state_nxt;
                frame_num <= frame_nxt;
                if (attack_enter)    attack_pend <= 1'b0;
                else if (attack_req) attack_pend <= 1'b1;
                if (hurt_enter)                hurt_pend <= 1'b0;
                else if (hit_in && !hit_prev) hurt_pend <= 1'b1;
            end
        end
    end

    assign character2_state = state;
    assign stand2  = (state == ST_STAND);
    assign attack  = (state == ST_ATTACK);
    assign move_l2 = (state == ST_MOVEL);
    assign move_r2 = (state == ST_MOVER);
    assign hurt    = (state == ST_HURT);
    assign die2    = (state == ST_DIE);

endmodule

// File: tb/tb_iori_anim_ctrl.sv
// Scoreboard bench for iori_anim_ctrl: each animation tick issued queues the
// hand-computed state/frame, and a monitor compares after every anim_tick.
module tb_iori_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk;
    logic [7:0] game_state;
    logic       move_l_req, move_r_req, attack_req, defense_req, hit_in, die_in;
    logic [7:0] character2_state, frame_num;
    logic       move_l2, move_r2, attack, hurt, die2, stand2, anim_tick;

    typedef struct {
        logic [7:0] st;
        logic [7:0] fr;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_tick_prev;

    always #5 Clk = ~Clk;

    iori_anim_ctrl dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_clk       (frame_clk),
        .game_state      (game_state),
        .move_l_req      (move_l_req),
        .move_r_req      (move_r_req),
        .attack_req      (attack_req),
        .defense_req     (defense_req),
        .hit_in          (hit_in),
        .die_in          (die_in),
        .character2_state(character2_state),
        .frame_num       (frame_num),
        .move_l2         (move_l2),
        .move_r2         (move_r2),
        .attack          (attack),
        .hurt            (hurt),
        .die2            (die2),
        .stand2          (stand2),
        .anim_tick       (anim_tick)
    );

    function automatic logic [7:0] exp_strobes(input logic [7:0] st);
        return {2'b00, st == 8'd0, st == 8'd1, st == 8'd2, st == 8'd3, st == 8'd5, st == 8'd6};
    endfunction

    function automatic logic [7:0] act_strobes();
        return {2'b00, stand2, attack, move_l2, move_r2, hurt, die2};
    endfunction

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // The registered state changes on the Clk after anim_tick, so compare one cycle later.
    initial begin : monitor
        exp_t e;
        mon_tick_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (mon_tick_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tick: got state %0d frame %0d, expected no tick",
                             character2_state, frame_num);
                end else begin
                    e = exp_q.pop_front();
                    check_output({e.name, "_state"}, character2_state, e.st);
                    check_output({e.name, "_frame"}, frame_num, e.fr);
                    check_output({e.name, "_strobes"}, act_strobes(), exp_strobes(e.st));
                end
            end
            mon_tick_prev = anim_tick;
        end
    end

    task automatic frame_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [7:0] st, input logic [7:0] fr);
        exp_t e;
        e.st = st;
        e.fr = fr;
        e.name = name;
        exp_q.push_back(e);
        frame_edges(4);
        wait_drain(name);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        Reset = 1'b1; frame_clk = 1'b0; game_state = 8'd0;
        move_l_req = 1'b0; move_r_req = 1'b0; attack_req = 1'b0;
        defense_req = 1'b0; hit_in = 1'b0; die_in = 1'b0;
        repeat (3) @(negedge Clk);
        check_output("reset_state", character2_state, 8'd0);
        check_output("reset_frame", frame_num, 8'd0);
        check_output("reset_strobes", act_strobes(), 8'h20);
        check_output("reset_tick", {7'd0, anim_tick}, 8'd0);
        Reset = 1'b0;

        // Outside game mode the divider is held, so these edges must not tick.
        frame_edges(4);
        repeat (6) @(negedge Clk);
        check_output("gated_state", character2_state, 8'd0);
        check_output("gated_frame", frame_num, 8'd0);

        game_state = 8'd1;
        @(negedge Clk);
        for (int i = 1; i <= 10; i++) apply_stimulus("stand_loop", 8'd0, 8'(i % 9));

        @(negedge Clk) attack_req = 1'b1;
        @(negedge Clk) attack_req = 1'b0;
        for (int i = 0; i < 6; i++) apply_stimulus("attack_pulse", 8'd1, 8'(i));
        apply_stimulus("attack_done", 8'd0, 8'd0);

        @(negedge Clk) attack_req = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus("attack_held", 8'd1, 8'(i));
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        check_output("reset_mid_state", character2_state, 8'd0);
        check_output("reset_mid_frame", frame_num, 8'd0);
        check_output("reset_mid_stand2", {7'd0, stand2}, 8'd1);
        check_output("reset_mid_attack", {7'd0, attack}, 8'd0);
        attack_req = 1'b0;
        @(negedge Clk) Reset = 1'b0;

        @(negedge Clk) attack_req = 1'b1;
        @(negedge Clk) attack_req = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus("atk_before_hit", 8'd1, 8'(i));
        @(negedge Clk) hit_in = 1'b1;
        repeat (2) @(negedge Clk);
        hit_in = 1'b0;
        apply_stimulus("hit_interrupt", 8'd5, 8'd0);
        for (int i = 1; i < 5; i++) apply_stimulus("hurt_seq", 8'd5, 8'(i));
        apply_stimulus("hurt_done", 8'd0, 8'd0);

        @(negedge Clk) hit_in = 1'b1;
        @(negedge Clk) hit_in = 1'b0;
        apply_stimulus("hurt_again", 8'd5, 8'd0);
        apply_stimulus("hurt_again", 8'd5, 8'd1);
        @(negedge Clk) die_in = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus("die_seq", 8'd6, 8'(i));
        for (int i = 0; i < 10; i++) apply_stimulus("die_hold", 8'd6, 8'd4);
        @(negedge Clk) game_state = 8'd2;
        @(negedge Clk) die_in = 1'b0;
        @(negedge Clk);
        check_output("gameover_state", character2_state, 8'd0);
        check_output("gameover_frame", frame_num, 8'd0);
        check_output("gameover_strobes", act_strobes(), 8'h20);

        @(negedge Clk);
        game_state = 8'd1;
        move_l_req = 1'b1;
        move_r_req = 1'b1;
        apply_stimulus("both_moves", 8'd0, 8'd1);
        move_r_req = 1'b0;
        for (int i = 0; i <= 10; i++) apply_stimulus("move_left", 8'd2, 8'(i % 10));
        move_l_req = 1'b0;
        move_r_req = 1'b1;
        defense_req = 1'b1;
        apply_stimulus("defense", 8'd4, 8'd0);
        apply_stimulus("defense_hold", 8'd4, 8'd0);
        defense_req = 1'b0;
        apply_stimulus("move_right", 8'd3, 8'd0);
        apply_stimulus("move_right", 8'd3, 8'd1);
        move_r_req = 1'b0;
        apply_stimulus("back_to_stand", 8'd0, 8'd0);

        repeat (4) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
